// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 receive path and its
// MAX7219-style register sink.
package spi_pkg;

  localparam int unsigned SPI_DATA_W      = 16;
  localparam int unsigned SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CLOSE
  } state_e;

  // MAX7219 register map (frame bits [11:8])
  localparam logic [3:0] ADDR_NOOP       = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0     = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1     = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2     = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3     = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4     = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5     = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6     = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7     = 4'h8;
  localparam logic [3:0] ADDR_DECODE     = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY  = 4'hA;
  localparam logic [3:0] ADDR_SCAN_LIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN   = 4'hC;
  localparam logic [3:0] ADDR_TEST       = 4'hF;

  typedef struct packed {
    logic [3:0] rsvd;
    logic [3:0] addr;
    logic [7:0] data;
  } max_word_t;

endpackage

// File: rtl/spi_slave_rx_sync_edge.sv
// N-stage synchronizer with a delayed copy for edge detection. Edges are
// suppressed until the chain has been refilled from the pin after reset.
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;
  logic [STAGES:0]   r_primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= {STAGES{RST_VAL}};
      r_dly    <= RST_VAL;
      r_primed <= '0;
    end else begin
      r_sync   <= {r_sync[STAGES-2:0], i_d};
      r_dly    <= r_sync[STAGES-1];
      r_primed <= {r_primed[STAGES-1:0], 1'b1};
    end
  end

  // a reset-value -> pin-value transition is not a real edge
  assign o_level  = r_sync[STAGES-1];
  assign o_rise_c = r_primed[STAGES] &  r_sync[STAGES-1] & ~r_dly;
  assign o_fall_c = r_primed[STAGES] & ~r_sync[STAGES-1] &  r_dly;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 frame receiver, MSB first, oversampled in the clk domain.
// Define SPI_RX_REGFILE_EN to add a 16x8 MAX7219-style register file (DATA_W=16).
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
`ifdef SPI_RX_REGFILE_EN
  output logic              busy,
  input  logic [3:0]        reg_addr,
  output logic [7:0]        reg_rdata
`else
  output logic              busy
`endif
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

  logic w_sclk_s, w_sclk_rise, w_sclk_fall;
  logic w_cs_s, w_cs_rise, w_cs_fall;
  logic w_mosi_s, w_mosi_rise, w_mosi_fall;

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_frame_err;
  logic              r_busy;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_d(sclk),
    .o_level(w_sclk_s), .o_rise_c(w_sclk_rise), .o_fall_c(w_sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .i_d(cs_n),
    .o_level(w_cs_s), .o_rise_c(w_cs_rise), .o_fall_c(w_cs_fall)
  );

  // same depth as sclk so the sampled bit lines up with the sclk rise
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .i_d(mosi),
    .o_level(w_mosi_s), .o_rise_c(w_mosi_rise), .o_fall_c(w_mosi_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          // counter saturates one past full so overlong frames stay visible
          if (w_sclk_rise) begin
            r_shift <= {r_shift[DATA_W-2:0], w_mosi_s};
            if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);
          end
          if (w_cs_rise) begin
            r_busy  <= 1'b0;
            r_state <= CLOSE;
          end
        end
        CLOSE: begin
          if (r_cnt == CNT_FULL) begin
            r_rx_data  <= r_shift;
            r_rx_valid <= 1'b1;
          end else begin
            r_frame_err <= 1'b1;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

`ifdef SPI_RX_REGFILE_EN
  logic [7:0] r_regs [16];
  max_word_t  w_word;

  assign w_word = max_word_t'(r_rx_data[15:0]);

  // writes to NOOP are dropped; the top nibble is don't-care
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else if (r_rx_valid && (w_word.addr != ADDR_NOOP)) begin
      r_regs[w_word.addr] <= w_word.data;
    end
  end

  assign reg_rdata = r_regs[reg_addr];

  logic w_unused;
  assign w_unused = &{1'b0, w_sclk_s, w_sclk_fall, w_cs_s, w_mosi_rise, w_mosi_fall,
                      w_word.rsvd};
`else
  logic w_unused;
  assign w_unused = &{1'b0, w_sclk_s, w_sclk_fall, w_cs_s, w_mosi_rise, w_mosi_fall};
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: expected words are queued as frames are
// driven and popped by a monitor when rx_valid/frame_err fire.
module tb_spi_slave_rx;
  import spi_pkg::*;

  localparam int unsigned DW = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk  = 1'b0;
  logic          mosi  = 1'b0;
  logic          cs_n  = 1'b1;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          busy;
`ifdef SPI_RX_REGFILE_EN
  logic [3:0]    reg_addr = 4'h0;
  logic [7:0]    reg_rdata;
  logic [7:0]    exp_regs [16];
`endif

  typedef struct packed {
    logic          is_err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] last_good = '0;

  always #10 clk = ~clk;

  spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
`ifdef SPI_RX_REGFILE_EN
    .busy(busy), .reg_addr(reg_addr), .reg_rdata(reg_rdata)
`else
    .busy(busy)
`endif
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, required finish before 5ms");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_good(input logic [DW-1:0] d);
    exp_q.push_back({1'b0, d});
    last_good = d;
`ifdef SPI_RX_REGFILE_EN
    if (d[11:8] != ADDR_NOOP) exp_regs[d[11:8]] = d[7:0];
`endif
  endtask

  task automatic push_err();
    exp_q.push_back({1'b1, last_good});
  endtask

  task automatic monitor();
    logic prev_evt = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_evt = 1'b0;
        continue;
      end
      if (rx_valid || frame_err) begin
        n_checks++;
        if (rx_valid && frame_err) begin
          n_fail++;
          $display("FAIL both_strobes: rx_valid=1 frame_err=1, required exclusive");
        end
        n_checks++;
        if (prev_evt) begin
          n_fail++;
          $display("FAIL strobe_width: strobe high two cycles, required one-cycle pulse");
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: rx_valid=%0b frame_err=%0b rx_data=%h, required no event",
                   rx_valid, frame_err, rx_data);
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if (frame_err !== e.is_err) begin
            n_fail++;
            $display("FAIL event_kind: frame_err=%0b, required %0b", frame_err, e.is_err);
          end
          n_checks++;
          if (rx_data !== e.data) begin
            n_fail++;
            $display("FAIL event_data: rx_data=%h, required %h", rx_data, e.data);
          end
        end
      end
      prev_evt = rx_valid | frame_err;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic send_bit(input logic b, input int half);
    mosi = b;
    wait_clk(half);
    sclk = 1'b1;
    wait_clk(half);
    sclk = 1'b0;
  endtask

  task automatic cs_high(input int half);
    wait_clk(half);
    cs_n = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] data, input int nbits, input int half);
    cs_low();
    for (int i = nbits - 1; i >= 0; i--) send_bit(data[i], half);
    cs_high(half);
    wait_clk(10);
  endtask

  task automatic test_reset();
    wait_clk(3);
    n_checks++;
    if (rx_data !== '0) begin n_fail++; $display("FAIL reset_rx_data: %h, required 0", rx_data); end
    n_checks++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: %0b, required 0", rx_valid); end
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: %0b, required 0", frame_err); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: %0b, required 0", busy); end
`ifdef SPI_RX_REGFILE_EN
    reg_addr = 4'h5;
    wait_clk(1);
    n_checks++;
    if (reg_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_reg: %h, required 00", reg_rdata); end
`endif
    rst_n = 1'b1;
    wait_clk(6);
  endtask

  task automatic test_single_frame();
    logic [15:0] w = 16'h0A5F;
    push_good(w);
    cs_low();
    for (int i = 15; i >= 0; i--) send_bit(w[i], 10);
    cs_high(10);
    wait_clk(3);
    n_checks++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: rx_valid=%0b at edge 3, required 0", rx_valid); end
    wait_clk(1);
    n_checks++;
    if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL latency_edge4: rx_valid=%0b at edge 4, required 1", rx_valid); end
    wait_drain("single");
    wait_clk(10);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: %0b, required 0", busy); end
`ifdef SPI_RX_REGFILE_EN
    reg_addr = ADDR_INTENSITY;
    wait_clk(1);
    n_checks++;
    if (reg_rdata !== 8'h5F) begin n_fail++; $display("FAIL reg_intensity: %h, required 5f", reg_rdata); end
`endif
  endtask

  task automatic test_back_to_back();
    push_good(16'h0155);
    push_good(16'h08AA);
    send_frame(32'h0155, 16, 10);
    send_frame(32'h08AA, 16, 10);
    wait_drain("b2b");
`ifdef SPI_RX_REGFILE_EN
    reg_addr = ADDR_DIGIT0;
    wait_clk(1);
    n_checks++;
    if (reg_rdata !== 8'h55) begin n_fail++; $display("FAIL reg_digit0: %h, required 55", reg_rdata); end
    reg_addr = ADDR_DIGIT7;
    wait_clk(1);
    n_checks++;
    if (reg_rdata !== 8'hAA) begin n_fail++; $display("FAIL reg_digit7: %h, required aa", reg_rdata); end
`endif
  endtask

  task automatic test_bad_lengths();
    push_err();
    push_err();
    send_frame(32'h00001234, 15, 5);
    send_frame(32'h0001ABCD, 17, 5);
    wait_drain("badlen");
    n_checks++;
    if (rx_data !== 16'h08AA) begin n_fail++; $display("FAIL badlen_hold: rx_data=%h, required 08aa", rx_data); end
  endtask

  task automatic test_empty_frame();
    push_err();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy_before: %0b, required 0", busy); end
    cs_low();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL empty_busy_during: %0b, required 1", busy); end
    wait_clk(14);
    cs_n = 1'b1;
    wait_clk(4);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy_after: %0b, required 0", busy); end
    wait_drain("empty");
    wait_clk(10);
  endtask

  task automatic test_reset_midframe();
    logic [15:0] w = 16'hC3A5;
    cs_low();
    for (int i = 15; i >= 8; i--) send_bit(w[i], 5);
    rst_n = 1'b0;
    last_good = '0;
`ifdef SPI_RX_REGFILE_EN
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
`endif
    wait_clk(2);
    n_checks++;
    if (rx_data !== '0) begin n_fail++; $display("FAIL midrst_rx_data: %h, required 0", rx_data); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: %0b, required 0", busy); end
    n_checks++;
    if ((rx_valid | frame_err) !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_strobes: valid=%0b err=%0b, required 0", rx_valid, frame_err);
    end
    rst_n = 1'b1;
    wait_clk(3);
    for (int i = 7; i >= 0; i--) send_bit(w[i], 5);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_not_entered: busy=%0b, required 0", busy); end
    cs_high(5);
    wait_clk(20);
    push_good(16'h0C01);
    send_frame(32'h0C01, 16, 10);
    wait_drain("midrst");
    n_checks++;
    if (rx_data !== 16'h0C01) begin n_fail++; $display("FAIL midrst_next: rx_data=%h, required 0c01", rx_data); end
`ifdef SPI_RX_REGFILE_EN
    reg_addr = ADDR_SHUTDOWN;
    wait_clk(1);
    n_checks++;
    if (reg_rdata !== 8'h01) begin n_fail++; $display("FAIL reg_shutdown: %h, required 01", reg_rdata); end
`endif
  endtask

  task automatic test_noop_frame();
    push_good(16'h0033);
    send_frame(32'h0033, 16, 10);
    wait_drain("noop");
    n_checks++;
    if (rx_data !== 16'h0033) begin n_fail++; $display("FAIL noop_data: rx_data=%h, required 0033", rx_data); end
`ifdef SPI_RX_REGFILE_EN
    wait_clk(2);
    for (int a = 0; a < 16; a++) begin
      reg_addr = 4'(a);
      wait_clk(1);
      n_checks++;
      if (reg_rdata !== exp_regs[a]) begin
        n_fail++;
        $display("FAIL noop_reg%0d: %h, required %h", a, reg_rdata, exp_regs[a]);
      end
    end
`endif
  endtask

  initial begin
`ifdef SPI_RX_REGFILE_EN
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
`endif
    fork
      monitor();
    join_none
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_bad_lengths();
    test_empty_frame();
    test_reset_midframe();
    test_noop_frame();
    wait_clk(20);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: %0d outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
